// File: rtl/trigger_bank.sv
// Multi-channel sticky trigger capture over a fixed acquisition window.
// Define TRIGGER_BANK_DIV2_EN to sample on every other cycle (window lasts 2*WINDOW cycles).

module trigger_lane (
  input  logic clk,
  input  logic rst,
  input  logic sample,
  input  logic wipe,
  input  logic capture,
  input  logic din,
  output logic trig,
  output logic rise
);
  logic din_prev;

  assign rise = din & ~din_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din_prev <= 1'b0;
      trig     <= 1'b0;
    end else begin
      // Edge history runs in every state so a level held across window open never triggers.
      if (sample) din_prev <= din;
      if (wipe)         trig <= 1'b0;
      else if (capture) trig <= trig | rise;
    end
  end
endmodule

module trigger_bank #(
  parameter int WIDTH     = 8,
  parameter int WINDOW    = 16,
  parameter int CNT_WIDTH = 5,
  parameter int HIT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 clear,
  input  logic [WIDTH-1:0]     din,
  output logic                 active,
  output logic                 done,
  output logic [WIDTH-1:0]     trig,
  output logic [HIT_WIDTH-1:0] hits,
  output logic                 any,
  output logic [CNT_WIDTH-1:0] first_cyc
);
  typedef enum logic [1:0] {IDLE, ACTIVE, HOLD} state_t;

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(WINDOW - 1);

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [WIDTH-1:0]     rise;
  logic                 sample, arm, wipe, capture;

  assign arm     = start & ~clear & (state != ACTIVE);
  assign wipe    = clear | arm;
  assign capture = (state == ACTIVE) & sample & ~clear;

`ifdef TRIGGER_BANK_DIV2_EN
  logic phase;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    phase <= 1'b0;
    else if (arm) phase <= 1'b0;
    else          phase <= ~phase;
  end
  assign sample = phase;
`else
  assign sample = 1'b1;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    trigger_lane u_lane (
      .clk     (clk),
      .rst     (reset),
      .sample  (sample),
      .wipe    (wipe),
      .capture (capture),
      .din     (din[i]),
      .trig    (trig[i]),
      .rise    (rise[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      active    <= 1'b0;
      done      <= 1'b0;
      any       <= 1'b0;
      first_cyc <= '0;
      cnt       <= '0;
    end else begin
      done <= 1'b0;
      if (clear) begin
        state     <= IDLE;
        active    <= 1'b0;
        any       <= 1'b0;
        first_cyc <= '0;
        cnt       <= '0;
      end else begin
        case (state)
          IDLE, HOLD: if (start) begin
            state     <= ACTIVE;
            active    <= 1'b1;
            any       <= 1'b0;
            first_cyc <= '0;
            cnt       <= '0;
          end
          ACTIVE: if (sample) begin
            if (!any && |rise) begin
              any       <= 1'b1;
              first_cyc <= cnt;
            end
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              state  <= HOLD;
              active <= 1'b0;
              done   <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    hits = '0;
    for (int i = 0; i < WIDTH; i++) hits = hits + HIT_WIDTH'(trig[i]);
  end
endmodule

// File: tb/tb_trigger_bank.sv
// Randomized self-checking bench for trigger_bank; window results come from a per-sample reference model.
module tb_trigger_bank;
  localparam int W   = 8;
  localparam int WIN = 16;
  localparam int CW  = 5;
  localparam int HW  = 4;
`ifdef TRIGGER_BANK_DIV2_EN
  localparam int SPS = 2;
`else
  localparam int SPS = 1;
`endif

  logic          clk = 1'b0;
  logic          reset, start, clear;
  logic [W-1:0]  din;
  logic          active, done, any;
  logic [W-1:0]  trig;
  logic [HW-1:0] hits;
  logic [CW-1:0] first_cyc;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] smp [WIN];

  trigger_bank #(.WIDTH(W), .WINDOW(WIN), .CNT_WIDTH(CW), .HIT_WIDTH(HW)) dut (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .din(din),
    .active(active), .done(done), .trig(trig), .hits(hits), .any(any), .first_cyc(first_cyc)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  // Opens a window with din=pre before start, feeds smp (held SPS cycles each), checks the result.
  task automatic run_window(input logic [W-1:0] pre, input bit b2b, input int mid_start,
                            input logic [W-1:0] glitch, input string tag);
    logic [W-1:0] e_trig, prev, r;
    bit           e_any, bad_act;
    int           e_first;
    e_trig = '0; e_any = 0; e_first = 0; bad_act = 0; prev = pre;
    for (int k = 0; k < WIN; k++) begin
      r = smp[k] & ~prev;
      e_trig |= r;
      if (!e_any && r != '0) begin e_any = 1; e_first = k; end
      prev = smp[k];
    end
    if (!b2b) begin din = pre; repeat (SPS) @(negedge clk); end
    din = pre; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= SPS * WIN; i++) begin
      if (active !== 1'b1 || done !== 1'b0) bad_act = 1;
      din = smp[(i - 1) / SPS];
      if (SPS == 2 && (i % 2) == 1) din = din | glitch;
      start = (i == mid_start);
      @(negedge clk);
    end
    start = 1'b0;
    n_cmp++;
    if (bad_act) begin n_bad++; $display("FAIL %s active_window: active/done wrong inside window, required active=1 done=0 for %0d cycles", tag, SPS*WIN); end
    n_cmp++;
    if (active !== 1'b0 || done !== 1'b1) begin n_bad++; $display("FAIL %s window_end: active=%b done=%b, required active=0 done=1", tag, active, done); end
    n_cmp++;
    if (trig !== e_trig) begin n_bad++; $display("FAIL %s trig: got %h, required %h", tag, trig, e_trig); end
    n_cmp++;
    if (hits !== HW'($countones(e_trig))) begin n_bad++; $display("FAIL %s hits: got %0d, required %0d", tag, hits, $countones(e_trig)); end
    n_cmp++;
    if (any !== e_any) begin n_bad++; $display("FAIL %s any: got %b, required %b", tag, any, e_any); end
    if (e_any) begin
      n_cmp++;
      if (first_cyc !== CW'(e_first)) begin n_bad++; $display("FAIL %s first_cyc: got %0d, required %0d", tag, first_cyc, e_first); end
    end
  endtask

  task automatic check_zero(input string tag);
    n_cmp++;
    if ({active, done, trig, hits, any, first_cyc} !== '0)
      begin n_bad++; $display("FAIL %s all_zero: active=%b done=%b trig=%h hits=%0d any=%b first=%0d, required all 0", tag, active, done, trig, hits, any, first_cyc); end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; clear = 1'b0; din = '0;
    repeat (3) @(negedge clk);
    check_zero("reset_held");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset_release");
  endtask

  task automatic test_quiet_window();
    for (int k = 0; k < WIN; k++) smp[k] = '0;
    run_window('0, 0, 0, '0, "quiet");
  endtask

  task automatic test_pattern();
    for (int k = 0; k < WIN; k++) smp[k] = (k < 3) ? 8'h00 : (k < 9) ? 8'h05 : 8'h85;
    run_window('0, 0, 0, '0, "pattern");
    n_cmp++;
    if (trig !== 8'h85 || hits !== 4'd3 || first_cyc !== 5'd3)
      begin n_bad++; $display("FAIL pattern_const: trig=%h hits=%0d first=%0d, required 85/3/3", trig, hits, first_cyc); end
  endtask

  task automatic test_held_high();
    for (int k = 0; k < WIN; k++) smp[k] = 8'hFF;
    run_window(8'hFF, 0, 0, '0, "held_high");
    for (int k = 0; k < WIN; k++) smp[k] = (k == 4 || k == 5) ? 8'hFE : 8'hFF;
    run_window(8'hFF, 0, 0, '0, "reraise");
    n_cmp++;
    if (trig !== 8'h01) begin n_bad++; $display("FAIL reraise_const: trig=%h, required 01", trig); end
  endtask

  task automatic test_random();
    logic [W-1:0] last;
    last = '0;
    for (int n = 0; n < 8; n++) begin
      bit b2b;
      logic [W-1:0] pre;
      b2b = (n % 2) == 1;
      pre = b2b ? last : W'($urandom);
      smp[0] = pre ^ W'($urandom & $urandom);
      for (int k = 1; k < WIN; k++) smp[k] = smp[k-1] ^ W'($urandom & $urandom & $urandom);
      run_window(pre, b2b, 0, '0, b2b ? "rand_b2b" : "rand");
      last = smp[WIN-1];
    end
  endtask

  task automatic test_mid_start();
    smp[0] = 8'h00;
    for (int k = 1; k < WIN; k++) smp[k] = smp[k-1] | W'(1 << ($urandom % W));
    run_window('0, 0, SPS * 5, '0, "mid_start");
  endtask

  task automatic test_clear();
    bit saw_done;
    din = '0; repeat (SPS) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    for (int i = 1; i <= SPS * 7; i++) begin
      din = (((i - 1) / SPS) >= 2) ? 8'h10 : 8'h00;
      @(negedge clk);
    end
    n_cmp++;
    if (trig !== 8'h10 || active !== 1'b1) begin n_bad++; $display("FAIL clear_pre: trig=%h active=%b, required 10/1", trig, active); end
    clear = 1'b1; @(negedge clk); clear = 1'b0;
    check_zero("clear_mid");
    saw_done = 0;
    repeat (SPS * WIN + 4) begin
      @(negedge clk);
      if (done !== 1'b0 || active !== 1'b0) saw_done = 1;
    end
    n_cmp++;
    if (saw_done) begin n_bad++; $display("FAIL clear_no_done: done/active rose after clear, required 0"); end
    start = 1'b1; clear = 1'b1; @(negedge clk); start = 1'b0; clear = 1'b0;
    check_zero("start_clear");
    repeat (3) @(negedge clk);
    check_zero("start_clear_later");
  endtask

  task automatic test_reset_mid();
    din = '0; repeat (SPS) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    for (int i = 0; i < SPS * 8; i++) begin din = W'($urandom); @(negedge clk); end
    reset = 1'b1; #1;
    check_zero("reset_mid_async");
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    check_zero("reset_mid_after");
  endtask

`ifdef TRIGGER_BANK_DIV2_EN
  task automatic test_glitch();
    for (int k = 0; k < WIN; k++) smp[k] = (k >= 10) ? 8'h40 : 8'h00;
    run_window('0, 0, 0, 8'h3C, "glitch");
  endtask
`endif

  initial begin
    test_reset();
    test_quiet_window();
    test_pattern();
    test_held_high();
    test_random();
    test_mid_start();
    test_clear();
    test_reset_mid();
`ifdef TRIGGER_BANK_DIV2_EN
    test_glitch();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
